// File: rtl/board_fsm.sv
// Tetris board controller for a vertical bar piece.
// Holds the per-cell colour store, sequences clear/spawn/paint/erase/lock,
// applies gravity and left/right moves, and streams one plot pixel per cycle
// to the VGA plotter through registered X/Y/colour/wren outputs.
module board_fsm #(
  parameter int BOARD_W   = 10,
  parameter int BOARD_H   = 20,
  parameter int CELL_PX   = 4,
  parameter int COLOUR_W  = 6,
  parameter int PIECE_LEN = 3,
  parameter int SPAWN_COL = 4,
  parameter int X_ORIGIN  = 0,
  parameter int Y_ORIGIN  = 0,
  parameter int FALL_DIV  = 25000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic                left,
  input  logic                right,
  input  logic [COLOUR_W-1:0] piece_colour,
  output logic [7:0]          X,
  output logic [6:0]          Y,
  output logic [COLOUR_W-1:0] colour,
  output logic                wren,
  output logic                busy,
  output logic                game_over
);

  localparam int CW = $clog2(BOARD_W + 1);
  localparam int RW = $clog2(BOARD_H + 1);
  localparam int PW = $clog2(CELL_PX + 1);
  localparam int KW = $clog2(PIECE_LEN + 1);
  localparam int FW = $clog2(FALL_DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SPAWN, S_PAINT, S_WAIT, S_ERASE, S_LOCK, S_OVER
  } state_t;

  typedef enum logic [1:0] {MV_FALL, MV_LEFT, MV_RIGHT} move_t;

  state_t              state_q, state_d;
  move_t               mv_q, mv_d;
  logic [PW-1:0]       px_q, px_d, py_q, py_d, px_nx, py_nx;
  logic [KW-1:0]       k_q, k_d;
  logic [CW-1:0]       cc_q, cc_d;
  logic [RW-1:0]       cr_q, cr_d;
  logic [FW-1:0]       fall_cnt_q, fall_cnt_d;
  logic                pend_q, pend_d;
  logic [7:0]          x_q, x_d;
  logic [6:0]          y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                wren_q, wren_d;

  // Piece position, latched piece colour and the board store.
  logic [CW-1:0]       col_q;
  logic [RW-1:0]       row_q;
  logic [COLOUR_W-1:0] pcol_q;
  logic [COLOUR_W-1:0] board_q [BOARD_H][BOARD_W];

  logic px_last, py_last, cell_done;
  logic occ_l, occ_r, occ_below, spawn_blk;
  logic left_ok, right_ok, fall_ok;
  logic fall_en, tick, pend_svc;
  logic spawn_go, apply_mv, lock_we, clr_we;

  assign px_last   = (px_q == PW'(CELL_PX - 1));
  assign py_last   = (py_q == PW'(CELL_PX - 1));
  assign cell_done = px_last && py_last;

  // Collision scan against the board as it stands at the start of the cycle.
  always_comb begin
    occ_l     = 1'b0;
    occ_r     = 1'b0;
    occ_below = 1'b0;
    spawn_blk = 1'b0;
    for (int r = 0; r < BOARD_H; r++) begin
      for (int c = 0; c < BOARD_W; c++) begin
        if (board_q[r][c] != '0) begin
          if (r >= int'(row_q) && r < int'(row_q) + PIECE_LEN) begin
            if (c == int'(col_q) - 1) occ_l = 1'b1;
            if (c == int'(col_q) + 1) occ_r = 1'b1;
          end
          if (r == int'(row_q) + PIECE_LEN && c == int'(col_q)) occ_below = 1'b1;
          if (c == SPAWN_COL && r < PIECE_LEN) spawn_blk = 1'b1;
        end
      end
    end
  end

  assign left_ok  = (col_q != '0) && !occ_l;
  assign right_ok = (int'(col_q) < BOARD_W - 1) && !occ_r;
  assign fall_ok  = (int'(row_q) + PIECE_LEN < BOARD_H) && !occ_below;

  // Next-state, pixel sequencing and registered-plot-output decode.
  always_comb begin
    state_d  = state_q;
    mv_d     = mv_q;
    px_d     = px_q;
    py_d     = py_q;
    k_d      = k_q;
    cc_d     = cc_q;
    cr_d     = cr_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    wren_d   = 1'b0;
    spawn_go = 1'b0;
    apply_mv = 1'b0;
    lock_we  = 1'b0;
    clr_we   = 1'b0;
    pend_svc = 1'b0;
    px_nx    = px_last ? '0 : px_q + PW'(1);
    py_nx    = px_last ? (py_last ? '0 : py_q + PW'(1)) : py_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (go) begin
          state_d = S_CLEAR;
          px_d    = '0;
          py_d    = '0;
          cc_d    = '0;
          cr_d    = '0;
        end
      end
      S_CLEAR: begin
        wren_d   = 1'b1;
        clr_we   = 1'b1;
        x_d      = 8'(X_ORIGIN + int'(cc_q) * CELL_PX + int'(px_q));
        y_d      = 7'(Y_ORIGIN + int'(cr_q) * CELL_PX + int'(py_q));
        colour_d = '0;
        px_d     = px_nx;
        py_d     = py_nx;
        if (cell_done) begin
          if (cc_q == CW'(BOARD_W - 1)) begin
            cc_d = '0;
            if (cr_q == RW'(BOARD_H - 1)) begin
              cr_d    = '0;
              state_d = S_SPAWN;
            end else begin
              cr_d = cr_q + RW'(1);
            end
          end else begin
            cc_d = cc_q + CW'(1);
          end
        end
      end
      S_SPAWN: begin
        if (spawn_blk) begin
          state_d = S_OVER;
        end else begin
          spawn_go = 1'b1;
          state_d  = S_PAINT;
          k_d      = '0;
          px_d     = '0;
          py_d     = '0;
        end
      end
      S_PAINT, S_ERASE: begin
        wren_d   = 1'b1;
        x_d      = 8'(X_ORIGIN + int'(col_q) * CELL_PX + int'(px_q));
        y_d      = 7'(Y_ORIGIN + (int'(row_q) + int'(k_q)) * CELL_PX + int'(py_q));
        colour_d = (state_q == S_PAINT) ? pcol_q : '0;
        px_d     = px_nx;
        py_d     = py_nx;
        if (cell_done) begin
          if (k_q == KW'(PIECE_LEN - 1)) begin
            k_d = '0;
            if (state_q == S_PAINT) begin
              state_d = S_WAIT;
            end else begin
              state_d  = S_PAINT;
              apply_mv = 1'b1;
            end
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      S_WAIT: begin
        if (left ^ right) begin
          // An illegal move is simply dropped; gravity gets the next cycle.
          if ((left && left_ok) || (right && right_ok)) begin
            mv_d    = left ? MV_LEFT : MV_RIGHT;
            state_d = S_ERASE;
            k_d     = '0;
            px_d    = '0;
            py_d    = '0;
          end
        end else if (pend_q) begin
          pend_svc = 1'b1;
          if (fall_ok) begin
            mv_d    = MV_FALL;
            state_d = S_ERASE;
            k_d     = '0;
            px_d    = '0;
            py_d    = '0;
          end else begin
            state_d = S_LOCK;
            k_d     = '0;
          end
        end
      end
      S_LOCK: begin
        lock_we = 1'b1;
        if (k_q == KW'(PIECE_LEN - 1)) begin
          k_d     = '0;
          state_d = S_SPAWN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gravity timer; a tick while a fall is already pending is absorbed.
  always_comb begin
    fall_en    = (state_q != S_IDLE) && (state_q != S_OVER);
    tick       = fall_en && (fall_cnt_q == FW'(FALL_DIV - 1));
    fall_cnt_d = fall_cnt_q;
    if (tick)         fall_cnt_d = '0;
    else if (fall_en) fall_cnt_d = fall_cnt_q + FW'(1);
    pend_d = pend_q;
    if (tick)          pend_d = 1'b1;
    else if (pend_svc) pend_d = 1'b0;
  end

  // Control and plot-output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mv_q       <= MV_FALL;
      px_q       <= '0;
      py_q       <= '0;
      k_q        <= '0;
      cc_q       <= '0;
      cr_q       <= '0;
      fall_cnt_q <= '0;
      pend_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      wren_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mv_q       <= mv_d;
      px_q       <= px_d;
      py_q       <= py_d;
      k_q        <= k_d;
      cc_q       <= cc_d;
      cr_q       <= cr_d;
      fall_cnt_q <= fall_cnt_d;
      pend_q     <= pend_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      wren_q     <= wren_d;
    end
  end

  // Piece position/colour updates and board writes (clear and lock).
  always_ff @(posedge clk) begin
    if (spawn_go) begin
      col_q  <= CW'(SPAWN_COL);
      row_q  <= '0;
      pcol_q <= (piece_colour == '0) ? '1 : piece_colour;
    end
    if (apply_mv) begin
      case (mv_q)
        MV_LEFT:  col_q <= col_q - CW'(1);
        MV_RIGHT: col_q <= col_q + CW'(1);
        default:  row_q <= row_q + RW'(1);
      endcase
    end
    for (int r = 0; r < BOARD_H; r++) begin
      for (int c = 0; c < BOARD_W; c++) begin
        if (clr_we && int'(cr_q) == r && int'(cc_q) == c)
          board_q[r][c] <= '0;
        else if (lock_we && int'(row_q) + int'(k_q) == r && int'(col_q) == c)
          board_q[r][c] <= pcol_q;
      end
    end
  end

  assign X         = x_q;
  assign Y         = y_q;
  assign colour    = colour_q;
  assign wren      = wren_q;
  assign busy      = !((state_q == S_IDLE) || (state_q == S_WAIT) || (state_q == S_OVER));
  assign game_over = (state_q == S_OVER);

endmodule
